// File: rtl/nixie_pkg.sv
// Shared field encodings and default timing constants for the clock-setting UI.
package nixie_pkg;

  typedef enum logic [1:0] {
    FLD_RUN     = 2'd0,
    FLD_HOURS   = 2'd1,
    FLD_MINUTES = 2'd2,
    FLD_SECONDS = 2'd3
  } field_e;

  // Defaults assume a 100 MHz clock.
  localparam logic [31:0] DEF_HOLD_CYCLES    = 32'd50_000_000;    // 500 ms
  localparam logic [31:0] DEF_REPEAT_CYCLES  = 32'd10_000_000;    // 100 ms
  localparam logic [31:0] DEF_TIMEOUT_CYCLES = 32'd3_000_000_000; // 30 s
  localparam logic [31:0] DEF_BLINK_CYCLES   = 32'd25_000_000;    // 2 Hz blink

  // MODE button walks RUN -> HOURS -> MINUTES -> SECONDS -> RUN.
  function automatic field_e next_field(input field_e f);
    case (f)
      FLD_RUN:     return FLD_HOURS;
      FLD_HOURS:   return FLD_MINUTES;
      FLD_MINUTES: return FLD_SECONDS;
      default:     return FLD_RUN;
    endcase
  endfunction

endpackage

// File: rtl/set_mode_controller_if.sv
// Button inputs and timekeeper/display outputs of the set-mode controller.
interface set_mode_controller_if;
  logic       modePulse;
  logic       upPulse;
  logic       downPulse;
  logic       upState;
  logic       downState;
  logic [1:0] field;
  logic       incPulse;
  logic       decPulse;
  logic       commitPulse;
  logic       blankField;

  // master: button/debounce side driving the controller
  modport master (
    output modePulse, upPulse, downPulse, upState, downState,
    input  field, incPulse, decPulse, commitPulse, blankField
  );

  // slave: the controller itself
  modport slave (
    input  modePulse, upPulse, downPulse, upState, downState,
    output field, incPulse, decPulse, commitPulse, blankField
  );
endinterface

// File: rtl/repeat_timer.sv
// Auto-repeat timer for one held button: first step after HOLD_CYCLES held
// samples, then one step every REPEAT_CYCLES. step_o is combinational so the
// parent can register it together with the direct press pulse.
module repeat_timer
  import nixie_pkg::*;
#(
  parameter logic [31:0] HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter logic [31:0] REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic held_i,
  input  logic clr_i,
  output logic step_o
);

  logic [31:0] cnt_q, cnt_d;
  logic        rep_q, rep_d;   // 1 once the initial hold delay has elapsed
  logic [31:0] limit;

  // Count held samples against the active limit; reload on every step.
  always_comb begin
    limit  = rep_q ? REPEAT_CYCLES : HOLD_CYCLES;
    cnt_d  = cnt_q;
    rep_d  = rep_q;
    step_o = 1'b0;
    if (clr_i || !held_i) begin
      cnt_d = '0;
      rep_d = 1'b0;
    end else if (cnt_q == limit - 32'd1) begin
      step_o = 1'b1;
      cnt_d  = '0;
      rep_d  = 1'b1;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Counter state, falling-edge clocked like the rest of the controller.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      rep_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rep_q <= rep_d;
    end
  end

endmodule

// File: rtl/set_mode_controller.sv
// Clock-setting UI: MODE cycles the selected field, UP/DOWN (with
// auto-repeat) step the timekeeper, idle timeout returns to RUN, and the
// selected field blinks. All state is on the falling clock edge.
module set_mode_controller
  import nixie_pkg::*;
#(
  parameter logic [31:0] HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter logic [31:0] REPEAT_CYCLES  = DEF_REPEAT_CYCLES,
  parameter logic [31:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [31:0] BLINK_CYCLES   = DEF_BLINK_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  set_mode_controller_if.slave  bus
);

  field_e      state_q, state_d;
  logic        inc_q, inc_d;
  logic        dec_q, dec_d;
  logic        commit_q, commit_d;
  logic        blank_q, blank_d;
  logic [31:0] idle_q, idle_d;
  logic [31:0] blink_q, blink_d;

  logic in_set, conflict, rpt_clr;
  logic up_step, dn_step, inc_req, dec_req, activity, timeout;

  assign in_set   = (state_q != FLD_RUN);
  // Both buttons held or both pressed together is treated as "no intent".
  assign conflict = (bus.upState && bus.downState) || (bus.upPulse && bus.downPulse);
  // MODE takes priority and RUN ignores the buttons, so repeat is cleared too.
  assign rpt_clr  = !in_set || bus.modePulse || conflict;

  repeat_timer #(
    .HOLD_CYCLES   (HOLD_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) u_up_rpt (
    .clk    (clk),
    .rst_n  (rst_n),
    .held_i (bus.upState),
    .clr_i  (rpt_clr),
    .step_o (up_step)
  );

  repeat_timer #(
    .HOLD_CYCLES   (HOLD_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) u_dn_rpt (
    .clk    (clk),
    .rst_n  (rst_n),
    .held_i (bus.downState),
    .clr_i  (rpt_clr),
    .step_o (dn_step)
  );

  assign inc_req  = bus.upPulse || up_step;
  assign dec_req  = bus.downPulse || dn_step;
  assign activity = bus.modePulse || bus.upPulse || bus.downPulse || up_step || dn_step;
  assign timeout  = in_set && !activity && (idle_q == TIMEOUT_CYCLES - 32'd1);

  // Field FSM next state plus step/commit strobes; inc and dec are exclusive.
  always_comb begin
    state_d  = state_q;
    commit_d = 1'b0;
    inc_d    = 1'b0;
    dec_d    = 1'b0;
    if (bus.modePulse) begin
      state_d  = next_field(state_q);
      commit_d = (state_q == FLD_SECONDS);
    end else if (timeout) begin
      state_d  = FLD_RUN;
      commit_d = 1'b1;
    end else if (in_set && !conflict) begin
      inc_d = inc_req && !dec_req;
      dec_d = dec_req && !inc_req;
    end
  end

  // Idle and blink counters; both reload explicitly and never wrap.
  always_comb begin
    idle_d  = idle_q + 32'd1;
    blink_d = blink_q + 32'd1;
    blank_d = blank_q;
    if (state_d == FLD_RUN || activity || state_d != state_q) begin
      idle_d = '0;
    end
    // Field is lit again right after any state change or step.
    if (state_d == FLD_RUN || state_d != state_q || inc_d || dec_d) begin
      blink_d = '0;
      blank_d = 1'b0;
    end else if (blink_q == BLINK_CYCLES - 32'd1) begin
      blink_d = '0;
      blank_d = !blank_q;
    end
  end

  // Registered state and outputs; reset clears everything immediately.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FLD_RUN;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      commit_q <= 1'b0;
      blank_q  <= 1'b0;
      idle_q   <= '0;
      blink_q  <= '0;
    end else begin
      state_q  <= state_d;
      inc_q    <= inc_d;
      dec_q    <= dec_d;
      commit_q <= commit_d;
      blank_q  <= blank_d;
      idle_q   <= idle_d;
      blink_q  <= blink_d;
    end
  end

  assign bus.field       = state_q;
  assign bus.incPulse    = inc_q;
  assign bus.decPulse    = dec_q;
  assign bus.commitPulse = commit_q;
  assign bus.blankField  = blank_q;

endmodule

// File: tb/tb_set_mode_controller.sv
// Scoreboard bench for set_mode_controller: a cycle reference model pushes
// expected outputs on each falling edge, a monitor pops and compares on the
// following rising edge.
module tb_set_mode_controller;

  localparam int HOLD    = 10;
  localparam int REP     = 4;
  localparam int TIMEOUT = 100;
  localparam int BLINK   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  set_mode_controller_if bus();

  set_mode_controller #(
    .HOLD_CYCLES    (32'd10),
    .REPEAT_CYCLES  (32'd4),
    .TIMEOUT_CYCLES (32'd100),
    .BLINK_CYCLES   (32'd8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int inc_seen = 0, dec_seen = 0, commit_seen = 0;

  // expected {field[1:0], inc, dec, commit, blank}
  logic [5:0] sb_q[$];

  // Reference model state: held lengths, and edge indices of last activity
  // and last blink restart.
  int n = 0;
  int m_fld = 0, m_hu = 0, m_hd = 0, m_last_act = 0, m_blink_r = 0;

  function automatic bit is_step(input int h);
    return (h >= HOLD) && (((h - HOLD) % REP) == 0);
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: one evaluation per falling edge.
  initial begin
    bit set, conflict, clr, us, ds, act, inc, dec, com, blank, ir, dr;
    int nf;
    forever begin
      @(negedge clk);
      n++;
      if (!rst_n) begin
        m_fld = 0; m_hu = 0; m_hd = 0; m_last_act = n; m_blink_r = n;
      end else begin
        set      = (m_fld != 0);
        conflict = (bus.upState && bus.downState) || (bus.upPulse && bus.downPulse);
        clr      = !set || bus.modePulse || conflict;
        m_hu     = (clr || !bus.upState)   ? 0 : m_hu + 1;
        m_hd     = (clr || !bus.downState) ? 0 : m_hd + 1;
        us       = !clr && is_step(m_hu);
        ds       = !clr && is_step(m_hd);
        act      = bus.modePulse || bus.upPulse || bus.downPulse || us || ds;
        inc = 0; dec = 0; com = 0; nf = m_fld;
        if (bus.modePulse) begin
          nf  = (m_fld + 1) % 4;
          com = (m_fld == 3);
        end else if (set && !act && (n - m_last_act) >= TIMEOUT) begin
          nf  = 0;
          com = 1;
        end else if (set && !conflict) begin
          ir = bus.upPulse || us;
          dr = bus.downPulse || ds;
          inc = ir && !dr;
          dec = dr && !ir;
        end
        if (act || nf != m_fld) m_last_act = n;
        if (nf != m_fld || inc || dec) m_blink_r = n;
        blank = (nf != 0) && ((((n - m_blink_r) / BLINK) % 2) == 1);
        m_fld = nf;
        sb_q.push_back({nf[1:0], inc, dec, com, blank});
      end
    end
  end

  // Monitor: compare DUT outputs half a cycle after the falling edge.
  initial begin
    logic [5:0] exp, got;
    forever begin
      @(posedge clk);
      if (sb_q.size() > 0) begin
        exp = sb_q.pop_front();
        got = {bus.field, bus.incPulse, bus.decPulse, bus.commitPulse, bus.blankField};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL outputs at %0t: got fld=%0d inc=%b dec=%b com=%b blank=%b expected fld=%0d inc=%b dec=%b com=%b blank=%b",
                   $time, got[5:4], got[3], got[2], got[1], got[0],
                   exp[5:4], exp[3], exp[2], exp[1], exp[0]);
        end
        if (got[3]) inc_seen++;
        if (got[2]) dec_seen++;
        if (got[1]) commit_seen++;
      end
    end
  end

  task automatic cyc(input logic m, input logic up, input logic dp,
                     input logic us, input logic ds);
    bus.modePulse = m;  bus.upPulse = up;  bus.downPulse = dp;
    bus.upState   = us; bus.downState = ds;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " field"},  int'(bus.field), 0);
    chk({tag, " inc"},    int'(bus.incPulse), 0);
    chk({tag, " dec"},    int'(bus.decPulse), 0);
    chk({tag, " commit"}, int'(bus.commitPulse), 0);
    chk({tag, " blank"},  int'(bus.blankField), 0);
  endtask

  initial begin
    logic uS, dS, nu, nd, mm;
    bus.modePulse = 0; bus.upPulse = 0; bus.downPulse = 0;
    bus.upState = 0; bus.downState = 0;

    // reset state
    @(negedge clk); #2;
    chk_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // MODE cycling with commit on the wrap to RUN
    for (int k = 0; k < 4; k++) begin
      cyc(1, 0, 0, 0, 0);
      idle(2);
    end

    // HOURS: press and hold UP for 30 cycles
    cyc(1, 0, 0, 0, 0);
    idle(2);
    inc_seen = 0;
    cyc(0, 1, 0, 1, 0);
    for (int i = 0; i < 29; i++) cyc(0, 0, 0, 1, 0);
    idle(10);
    chk("hold_repeat inc count", inc_seen, 7);

    // MINUTES: both buttons held -> no steps
    cyc(1, 0, 0, 0, 0);
    inc_seen = 0; dec_seen = 0;
    for (int i = 0; i < 40; i++) cyc(0, i == 0, i == 0, 1, 1);
    idle(3);
    chk("both_held step count", inc_seen + dec_seen, 0);

    // SECONDS -> RUN, then idle timeout out of HOURS
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    idle(2);
    commit_seen = 0;
    cyc(1, 0, 0, 0, 0);
    idle(110);
    chk("timeout commit count", commit_seen, 1);
    chk("timeout field", int'(bus.field), 0);

    // HOURS blink, DOWN press during the dark half
    cyc(1, 0, 0, 0, 0);
    idle(11);
    cyc(0, 0, 1, 0, 1);
    idle(20);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    idle(2);

    // SECONDS: reset in the middle of auto-repeat
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 0);
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, 1, 0);
    #1 rst_n = 1'b0;
    sb_q.delete();
    #1 chk_zero("async_reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    inc_seen = 0; commit_seen = 0;
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0);
    idle(3);
    chk("post_reset inc count", inc_seen, 0);
    chk("post_reset commit count", commit_seen, 0);

    // random button activity
    uS = 0; dS = 0;
    for (int i = 0; i < 2000; i++) begin
      mm = ($urandom_range(0, 39) == 0);
      nu = uS;
      nd = dS;
      if ($urandom_range(0, 14) == 0) nu = !uS;
      if ($urandom_range(0, 19) == 0) nd = !dS;
      cyc(mm, nu && !uS, nd && !dS, nu, nd);
      uS = nu;
      dS = nd;
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
